// File: rtl/mprj_bram_wb_if.sv
// mprj_bram_wb_if: Wishbone slave bus plus BRAM macro port bundle for mprj_bram_wb
//   Wishbone: wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i[3:0], wbs_adr_i[31:0], wbs_dat_i[31:0] -> wbs_ack_o, wbs_dat_o[31:0]
//   BRAM:     bram_en, bram_we[3:0], bram_addr[ADDR_WIDTH-1:0], bram_di[31:0] <- bram_do[31:0]
//   slave modport = bridge side, master modport = bus master / BRAM macro side
interface mprj_bram_wb_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  wbs_cyc_i;
   logic                  wbs_stb_i;
   logic                  wbs_we_i;
   logic [3:0]            wbs_sel_i;
   logic [31:0]           wbs_adr_i;
   logic [31:0]           wbs_dat_i;
   logic                  wbs_ack_o;
   logic [31:0]           wbs_dat_o;
   logic                  bram_en;
   logic [3:0]            bram_we;
   logic [ADDR_WIDTH-1:0] bram_addr;
   logic [31:0]           bram_di;
   logic [31:0]           bram_do;
   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, bram_do,
      output wbs_ack_o, wbs_dat_o, bram_en, bram_we, bram_addr, bram_di
   );
   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, bram_do,
      input  wbs_ack_o, wbs_dat_o, bram_en, bram_we, bram_addr, bram_di
   );
endinterface

// File: rtl/mprj_bram_wb.sv
// mprj_bram_wb: Wishbone slave fronting the user-project BRAM with a programmable pre-access delay
//   wb_clk_i    : clock, all logic on the rising edge
//   wb_rstn_i   : asynchronous active-low reset
//   wb          : mprj_bram_wb_if.slave (Wishbone slave + 1-cycle-latency BRAM port)
//   la_data_out : access statistics when MPRJ_BRAM_STATS_EN is defined, otherwise 0
//   Optional feature macro: MPRJ_BRAM_STATS_EN
module mprj_bram_wb #(
   parameter logic [31:0] BASE_ADDR  = 32'h3800_0000,
   parameter int          ADDR_WIDTH = 10,
   parameter int          DELAYS     = 10
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rstn_i,
   mprj_bram_wb_if.slave        wb,
   output logic [127:0]         la_data_out
);
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_CAPTURE, S_ACK} state_t;
   // counter value seen in the final WAIT cycle
   localparam logic [7:0] LAST_WAIT = (DELAYS == 0) ? 8'd0 : 8'(DELAYS - 1);
   state_t                r_state, w_next;
   logic [7:0]            r_cnt;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic                  r_we;
   logic [3:0]            r_sel;
   logic [31:0]           r_dat;
   logic                  r_ack;
   logic [31:0]           r_dat_o;
   logic                  w_hit;
   logic                  w_accept;
   assign w_hit    = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:24] == BASE_ADDR[31:24]);
   assign w_accept = (r_state == S_IDLE) & w_hit;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    w_next = !w_hit ? S_IDLE : (DELAYS == 0) ? S_ACCESS : S_WAIT;
         S_WAIT:    w_next = !wb.wbs_cyc_i ? S_IDLE : (r_cnt == LAST_WAIT) ? S_ACCESS : S_WAIT;
         // an access already issued is not undone; dropping cyc only suppresses the ack
         S_ACCESS:  w_next = !wb.wbs_cyc_i ? S_IDLE : r_we ? S_ACK : S_CAPTURE;
         S_CAPTURE: w_next = wb.wbs_cyc_i ? S_ACK : S_IDLE;
         S_ACK:     w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_waddr <= '0;
         r_we    <= 1'b0;
         r_sel   <= '0;
         r_dat   <= '0;
         r_ack   <= 1'b0;
         r_dat_o <= '0;
      end else begin
         r_state <= w_next;
         r_ack   <= (w_next == S_ACK);
         if (w_accept) begin
            r_waddr <= wb.wbs_adr_i[ADDR_WIDTH+1:2];
            r_we    <= wb.wbs_we_i;
            r_sel   <= wb.wbs_sel_i;
            r_dat   <= wb.wbs_dat_i;
            r_cnt   <= '0;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (r_state == S_CAPTURE && wb.wbs_cyc_i) r_dat_o <= wb.bram_do;
      end
   end
   assign wb.bram_en   = (r_state == S_ACCESS);
   assign wb.bram_we   = (r_state == S_ACCESS && r_we) ? r_sel : 4'b0000;
   assign wb.bram_addr = r_waddr;
   assign wb.bram_di   = r_dat;
   assign wb.wbs_ack_o = r_ack;
   assign wb.wbs_dat_o = r_dat_o;
`ifdef MPRJ_BRAM_STATS_EN
   logic [31:0] r_rd_cnt, r_wr_cnt, r_wait_cnt, r_last_adr;
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         r_rd_cnt   <= '0;
         r_wr_cnt   <= '0;
         r_wait_cnt <= '0;
         r_last_adr <= '0;
      end else begin
         if (r_state == S_ACK && !r_we && r_rd_cnt != 32'hFFFF_FFFF) r_rd_cnt <= r_rd_cnt + 32'd1;
         if (r_state == S_ACK && r_we && r_wr_cnt != 32'hFFFF_FFFF) r_wr_cnt <= r_wr_cnt + 32'd1;
         if (r_state == S_WAIT && r_wait_cnt != 32'hFFFF_FFFF) r_wait_cnt <= r_wait_cnt + 32'd1;
         if (w_accept) r_last_adr <= wb.wbs_adr_i;
      end
   end
   assign la_data_out = {r_last_adr, r_wait_cnt, r_wr_cnt, r_rd_cnt};
`else
   assign la_data_out = '0;
`endif
endmodule

// File: doc/mprj_bram_wb.md
Name: mprj_bram_wb

Overview:
Wishbone slave that fronts the user-project BRAM (mprjram, base 0x3800_0000). Firmware such as qsort executes from this region. The block sits between the Caravel management Wishbone bus (wbs_*) and a single-port, 1-cycle-latency BRAM macro. It inserts a programmable wait delay before each BRAM access and generates wbs_ack_o. It optionally exposes access statistics on the logic-analyzer bus.

Parameters:
BASE_ADDR, 32'h3800_0000, window base; decode compares wbs_adr_i[31:24] with BASE_ADDR[31:24]
ADDR_WIDTH, 10, BRAM word-address width (1024 x 32-bit = 4 KB)
DELAYS, 10, wait cycles inserted before the BRAM access (0..255)

Ports:
wb_clk_i  in  1  single clock; all logic on rising edge
wb_rstn_i  in  1  asynchronous, active-low reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  1 = write
wbs_sel_i  in  4  byte lane enables
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge, registered
wbs_dat_o  out  32  read data, registered
bram_en  out  1  BRAM enable
bram_we  out  4  BRAM byte write enables
bram_addr  out  ADDR_WIDTH  word address = latched adr[ADDR_WIDTH+1:2]
bram_di  out  32  BRAM write data
bram_do  in  32  BRAM read data, valid 1 cycle after bram_en
la_data_out  out  128  statistics (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state IDLE; counter 0; wbs_ack_o=0, wbs_dat_o=0, bram_en=0, bram_we=0, bram_addr=0, bram_di=0, la_data_out=0.
- hit = cyc & stb & (adr[31:24]==BASE_ADDR[31:24]). Non-hit requests are ignored: no ack, no bram_en. Address bits above ADDR_WIDTH+1 inside the window alias (wrap).
- States: IDLE, WAIT, ACCESS, CAPTURE, ACK.
- IDLE: on hit at edge 0, latch adr/we/sel/dat and clear the counter. Go to WAIT, or to ACCESS if DELAYS==0.
- WAIT: counter increments each cycle. After DELAYS cycles (cycles 1..DELAYS), go to ACCESS.
- ACCESS (cycle DELAYS+1): bram_en=1, bram_we = we ? sel : 4'b0000, bram_addr and bram_di from the latches. Reads go to CAPTURE; writes go to ACK.
- CAPTURE (read only, cycle DELAYS+2): register bram_do into wbs_dat_o; go to ACK.
- ACK: wbs_ack_o=1 for exactly one cycle.
  - Read: ack in cycle DELAYS+3. Write: ack in cycle DELAYS+2.
  - Then IDLE. The next request can be sampled the cycle after ACK.
- wbs_dat_o holds its last read value between reads; writes do not alter it.
- bram_en and bram_we are 0 in every state except ACCESS.
- wbs_sel_i==0 write: ACCESS occurs with bram_we=0; ack still returned.
- Abort (cyc low in WAIT/CAPTURE, or observed in ACCESS): go to IDLE next cycle, no ack.
  - A write aborted before ACCESS never reaches the BRAM.
  - An ACCESS already issued is not undone.
- stb/adr/dat changes after acceptance are ignored; only the latched values are used.
- Reset mid-transaction: immediate IDLE, no ack, no BRAM strobe.

Optional Feature:
MPRJ_BRAM_STATS_EN defined:
- la_data_out[31:0] = completed read count.
- la_data_out[63:32] = completed write count.
- la_data_out[95:64] = total WAIT cycles.
- la_data_out[127:96] = byte address of the last accepted request.
- Counters increment on ACK (reads/writes) or per WAIT cycle, and saturate at 32'hFFFF_FFFF.
- All fields reset to 0.

Undefined: la_data_out tied to 0; no stats registers are synthesized.

Test Plan:
1. DELAYS=10; preload word 5 = 32'hDEAD_BEEF; read 0x3800_0014 -> bram_en only in cycle 11 with bram_addr=5; wbs_ack_o=1 only in cycle 13; wbs_dat_o=32'hDEAD_BEEF.
2. Word 3 = 32'h1111_1111; write 0x3800_000C, dat=32'hAABB_CCDD, sel=4'b0011 -> bram_we=4'b0011 in cycle 11; ack in cycle 12; readback returns 32'h1111_CCDD.
3. Read 0x3000_0000, cyc/stb held 30 cycles -> no ack, no bram_en; the next read of 0x3800_0000 completes normally.
4. DELAYS=10 write, drop cyc in cycle 5 -> no bram_we, no ack, IDLE in cycle 6; readback shows the old value.
5. Assert wb_rstn_i low in cycle 7 of a read -> all outputs 0 immediately; after release, a new read acks in cycle 13. Separately, DELAYS=0 -> read ack in cycle 3, write ack in cycle 2.
6. MPRJ_BRAM_STATS_EN, DELAYS=10, 3 reads + 2 writes -> la_data_out[31:0]=3, [63:32]=2, [95:64]=50, [127:96]=last address; without the macro, la_data_out stays 0.
